// File: rtl/bitstream_frame_seq.sv
// Serial frame sequencer: hunts for a sync word, reads a length field, forwards
// payload bits and drives the serial CRC-8 checker, reporting a verdict per frame.
module bitstream_frame_seq #(
  parameter logic [7:0] SYNC_WORD = 8'hB5,
  parameter int         LEN_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  output logic       payload_bit_o,
  output logic       payload_valid_o,
  output logic       crc_en_o,
  output logic       crc_data_o,
  output logic       crc_capture_o,
  input  logic       crc_flag_i,
  output logic       frame_done_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam logic [2:0] S_HUNT    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CRC     = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;
  localparam logic [1:0] ERR_CRC      = 2'd3;

  // Shared bit counter: LEN_W-1 down to 0 for the length field, 7 down to 0 for the CRC byte.
  localparam int CNT_W = (LEN_W > 8) ? $clog2(LEN_W) : 3;

  logic [2:0]       state_q;
  logic [7:0]       sync_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             res_seen_q;

  logic             accept;
  logic [7:0]       sync_next;
  logic [LEN_W-1:0] len_next;

  assign bit_ready_o = (state_q != S_CAPTURE) && (state_q != S_RESULT);
  assign busy_o      = (state_q != S_HUNT);
  assign accept      = bit_valid_i & bit_ready_o;
  assign sync_next   = {sync_q[6:0], bit_i};
  assign len_next    = {len_q[LEN_W-2:0], bit_i};

  // All outputs are registered, so each phase becomes visible one cycle after
  // its state is entered; RESULT holds two cycles so the verdict pulse is seen
  // while bit_ready_o is still low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= S_HUNT;
      sync_q          <= '0;
      len_q           <= '0;
      rem_q           <= '0;
      cnt_q           <= '0;
      res_seen_q      <= 1'b0;
      payload_bit_o   <= 1'b0;
      payload_valid_o <= 1'b0;
      crc_en_o        <= 1'b0;
      crc_data_o      <= 1'b0;
      crc_capture_o   <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      err_code_o      <= ERR_NONE;
    end else begin
      payload_valid_o <= 1'b0;
      crc_en_o        <= 1'b0;
      crc_data_o      <= 1'b0;
      crc_capture_o   <= 1'b0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;

      case (state_q)
        S_HUNT: begin
          if (accept) begin
            if (sync_next == SYNC_WORD) begin
              state_q    <= S_LEN;
              sync_q     <= '0;
              len_q      <= '0;
              cnt_q      <= CNT_W'(LEN_W - 1);
              err_code_o <= ERR_NONE;
            end else begin
              sync_q <= sync_next;
            end
          end
        end

        S_LEN: begin
          if (accept) begin
            len_q <= len_next;
            if (cnt_q == '0) begin
              if (len_next == '0) begin
                frame_err_o <= 1'b1;
                err_code_o  <= ERR_ZERO_LEN;
                state_q     <= S_HUNT;
              end else begin
                rem_q   <= len_next;
                state_q <= S_PAYLOAD;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end

        S_PAYLOAD: begin
          if (bit_valid_i) begin
            payload_bit_o   <= bit_i;
            payload_valid_o <= 1'b1;
            crc_en_o        <= 1'b1;
            crc_data_o      <= bit_i;
            rem_q           <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q <= S_CRC;
              cnt_q   <= CNT_W'(7);
            end
          end else begin
            // A gap would break the checker's one-bit-per-clock stream.
            frame_err_o <= 1'b1;
            err_code_o  <= ERR_UNDERRUN;
            state_q     <= S_HUNT;
          end
        end

        S_CRC: begin
          if (bit_valid_i) begin
            crc_en_o   <= 1'b1;
            crc_data_o <= bit_i;
            if (cnt_q == '0) begin
              state_q <= S_CAPTURE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else begin
            frame_err_o <= 1'b1;
            err_code_o  <= ERR_UNDERRUN;
            state_q     <= S_HUNT;
          end
        end

        S_CAPTURE: begin
          crc_en_o      <= 1'b1;
          crc_capture_o <= 1'b1;
          res_seen_q    <= 1'b0;
          state_q       <= S_RESULT;
        end

        S_RESULT: begin
          // First cycle: the checker flag is valid at this edge (capture strobe is visible).
          if (!res_seen_q) begin
            res_seen_q <= 1'b1;
            if (crc_flag_i) begin
              frame_err_o <= 1'b1;
              err_code_o  <= ERR_CRC;
            end else begin
              frame_done_o <= 1'b1;
            end
          end else begin
            res_seen_q <= 1'b0;
            state_q    <= S_HUNT;
          end
        end

        default: begin
          state_q <= S_HUNT;
          sync_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_frame_seq.sv
// Directed bench for bitstream_frame_seq: sync hunting, zero length, good frame,
// CRC mismatch, underrun and reset mid-payload, with hand-computed expectations.
module tb_bitstream_frame_seq;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       bit_i;
  logic       bit_valid_i;
  logic       bit_ready_o;
  logic       payload_bit_o;
  logic       payload_valid_o;
  logic       crc_en_o;
  logic       crc_data_o;
  logic       crc_capture_o;
  logic       crc_flag_i;
  logic       frame_done_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  int e0;

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (crc_en_o) en_cnt++;

  bitstream_frame_seq #(.SYNC_WORD(8'hB5), .LEN_W(16)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .bit_i          (bit_i),
    .bit_valid_i    (bit_valid_i),
    .bit_ready_o    (bit_ready_o),
    .payload_bit_o  (payload_bit_o),
    .payload_valid_o(payload_valid_o),
    .crc_en_o       (crc_en_o),
    .crc_data_o     (crc_data_o),
    .crc_capture_o  (crc_capture_o),
    .crc_flag_i     (crc_flag_i),
    .frame_done_o   (frame_done_o),
    .frame_err_o    (frame_err_o),
    .err_code_o     (err_code_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid_i = 1'b1;
    bit_i       = b;
    tick();
  endtask

  task automatic idle();
    bit_valid_i = 1'b0;
    tick();
  endtask

  task automatic send_sync();
    logic [7:0] w;
    w = 8'hB5;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_len(input logic [15:0] l);
    for (int i = 15; i >= 0; i--) send_bit(l[i]);
  endtask

  task automatic run_frame(input string pfx, input logic [7:0] pay, input logic [7:0] crc,
                           input logic flag);
    int base;
    send_sync();
    chk({pfx, "_sync_busy"}, 32'(busy_o), 32'd1);
    chk({pfx, "_sync_errcode"}, 32'(err_code_o), 32'd0);
    send_len(16'd8);
    base = en_cnt;
    for (int i = 7; i >= 0; i--) begin
      send_bit(pay[i]);
      chk({pfx, "_pay_valid"}, 32'(payload_valid_o), 32'd1);
      chk({pfx, "_pay_bit"}, 32'(payload_bit_o), 32'(pay[i]));
      chk({pfx, "_pay_crc_en"}, 32'(crc_en_o), 32'd1);
      chk({pfx, "_pay_crc_data"}, 32'(crc_data_o), 32'(pay[i]));
    end
    for (int i = 7; i >= 0; i--) begin
      send_bit(crc[i]);
      chk({pfx, "_crc_pay_valid"}, 32'(payload_valid_o), 32'd0);
      chk({pfx, "_crc_data"}, 32'(crc_data_o), 32'(crc[i]));
      chk({pfx, "_crc_en"}, 32'(crc_en_o), 32'd1);
    end
    chk({pfx, "_k1_ready"}, 32'(bit_ready_o), 32'd0);
    bit_valid_i = 1'b0;
    crc_flag_i  = flag;
    tick();
    chk({pfx, "_k2_capture"}, 32'(crc_capture_o), 32'd1);
    chk({pfx, "_k2_en"}, 32'(crc_en_o), 32'd1);
    chk({pfx, "_k2_data"}, 32'(crc_data_o), 32'd0);
    chk({pfx, "_k2_ready"}, 32'(bit_ready_o), 32'd0);
    tick();
    chk({pfx, "_k3_done"}, 32'(frame_done_o), 32'(!flag));
    chk({pfx, "_k3_err"}, 32'(frame_err_o), 32'(flag));
    chk({pfx, "_k3_errcode"}, 32'(err_code_o), flag ? 32'd3 : 32'd0);
    chk({pfx, "_k3_en"}, 32'(crc_en_o), 32'd0);
    chk({pfx, "_k3_capture"}, 32'(crc_capture_o), 32'd0);
    chk({pfx, "_k3_ready"}, 32'(bit_ready_o), 32'd0);
    crc_flag_i = 1'b0;
    tick();
    chk({pfx, "_k4_ready"}, 32'(bit_ready_o), 32'd1);
    chk({pfx, "_k4_busy"}, 32'(busy_o), 32'd0);
    chk({pfx, "_k4_done"}, 32'(frame_done_o), 32'd0);
    chk({pfx, "_k4_err"}, 32'(frame_err_o), 32'd0);
    chk({pfx, "_en_window"}, 32'(en_cnt - base), 32'd17);
  endtask

  initial begin
    logic [6:0] pre;
    rst_ni      = 1'b0;
    bit_i       = 1'b0;
    bit_valid_i = 1'b0;
    crc_flag_i  = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(bit_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_outs", {25'd0, payload_bit_o, payload_valid_o, crc_en_o, crc_data_o,
                     crc_capture_o, frame_done_o, frame_err_o}, 32'd0);
    chk("rst_errcode", 32'(err_code_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Sync hunting with gaps: B5 completes on the 8th bit.
    pre = 7'b1011010;
    for (int i = 6; i >= 0; i--) begin
      send_bit(pre[i]);
      if (i % 2 == 0) idle();
      chk("hunt_no_false_sync", 32'(busy_o), 32'd0);
    end
    send_bit(1'b1);
    chk("hunt_sync_busy", 32'(busy_o), 32'd1);
    chk("hunt_sync_ready", 32'(bit_ready_o), 32'd1);

    // Zero-length field after that sync.
    e0 = en_cnt;
    for (int i = 0; i < 15; i++) begin
      send_bit(1'b0);
      if (i == 7) idle();
    end
    send_bit(1'b0);
    chk("zlen_err", 32'(frame_err_o), 32'd1);
    chk("zlen_errcode", 32'(err_code_o), 32'd1);
    chk("zlen_busy", 32'(busy_o), 32'd0);
    chk("zlen_done", 32'(frame_done_o), 32'd0);
    idle();
    chk("zlen_err_pulse", 32'(frame_err_o), 32'd0);
    chk("zlen_no_en", 32'(en_cnt - e0), 32'd0);

    run_frame("good", 8'h3C, 8'hA7, 1'b0);
    idle();
    run_frame("mism", 8'h3C, 8'hA7, 1'b1);
    idle();

    // Underrun after three payload bits.
    send_sync();
    chk("und_sync_errcode", 32'(err_code_o), 32'd0);
    send_len(16'd8);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("und_en_before", 32'(crc_en_o), 32'd1);
    idle();
    chk("und_err", 32'(frame_err_o), 32'd1);
    chk("und_errcode", 32'(err_code_o), 32'd2);
    chk("und_en", 32'(crc_en_o), 32'd0);
    chk("und_busy", 32'(busy_o), 32'd0);
    chk("und_ready", 32'(bit_ready_o), 32'd1);
    idle();
    chk("und_err_pulse", 32'(frame_err_o), 32'd0);

    // Reset asserted mid-payload.
    send_sync();
    send_len(16'd8);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("mid_en", 32'(crc_en_o), 32'd1);
    rst_ni = 1'b0;
    #2;
    chk("mid_rst_outs", {25'd0, payload_bit_o, payload_valid_o, crc_en_o, crc_data_o,
                         crc_capture_o, frame_done_o, frame_err_o}, 32'd0);
    chk("mid_rst_ready", 32'(bit_ready_o), 32'd1);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    bit_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    run_frame("post", 8'h96, 8'h5E, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
